// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port integer register file.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_REG  = 0;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: register select, x0/clear masking, write bypass
// and (with REGFILE_PARITY_EN) stored-parity check.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                  i_ready,
  input  logic [AW-1:0]         i_rd_addr,
  input  logic [NREGS*XLEN-1:0] i_regs,
`ifdef REGFILE_PARITY_EN
  input  logic [NREGS-1:0]      i_par,
  output logic                  o_rd_perr,
`endif
  input  logic                  i_wr_accept,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [XLEN-1:0]       i_wr_data,
  output logic [XLEN-1:0]       o_rd_data
);

  logic [XLEN-1:0] w_stored;
  logic            w_zero;
  logic            w_byp;

  assign w_stored = i_regs[int'(i_rd_addr)*XLEN +: XLEN];
  // The file reads as all-zero until the clear sweep finishes.
  assign w_zero   = (i_rd_addr == AW'(ZERO_REG)) || !i_ready;
  assign w_byp    = (BYPASS != 0) && i_wr_accept && (i_rd_addr == i_wr_addr);

  always_comb begin
    o_rd_data = w_stored;
    if (w_zero)
      o_rd_data = '0;
    else if (w_byp)
      o_rd_data = i_wr_data;
  end

`ifdef REGFILE_PARITY_EN
  assign o_rd_perr = !w_zero && !w_byp && (^{w_stored, i_par[i_rd_addr]});
`endif

endmodule

// File: rtl/regfile_mp.sv
// Parametrised NRD-read / 1-write integer register file with post-reset clear
// sweep and hard-wired zero register. Optional parity: define REGFILE_PARITY_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  output logic                wr_accept,
  output logic                ready,
`ifdef REGFILE_PARITY_EN
  output logic [NRD-1:0]      rd_perr,
`endif
  output logic                busy
);

  rf_state_e       r_state;
  rf_state_e       w_state_nxt;
  logic [AW-1:0]   r_ptr;
  logic [AW-1:0]   w_ptr_nxt;
  logic            w_clr_we;
  logic [XLEN-1:0] r_regs [NREGS];
  logic [NREGS*XLEN-1:0] w_regs_flat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RF_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_clr_we    = 1'b0;
    case (r_state)
      RF_CLEAR: begin
        w_clr_we  = 1'b1;
        w_ptr_nxt = r_ptr + 1'b1;
        if (r_ptr == AW'(NREGS - 1))
          w_state_nxt = RF_READY;
      end
      RF_READY: w_state_nxt = RF_READY;
      default:  w_state_nxt = RF_CLEAR;
    endcase
  end

  assign ready     = (r_state == RF_READY);
  assign busy      = !ready;
  assign wr_accept = ready && wr_en && (wr_addr != AW'(ZERO_REG));

  // Storage is deliberately not reset; the sweep zeroes it one entry per clock.
  always_ff @(posedge clk) begin
    if (w_clr_we)
      r_regs[r_ptr] <= '0;
    else if (wr_accept)
      r_regs[wr_addr] <= wr_data;
  end

`ifdef REGFILE_PARITY_EN
  logic             r_par [NREGS];
  logic [NREGS-1:0] w_par_flat;

  always_ff @(posedge clk) begin
    if (w_clr_we)
      r_par[r_ptr] <= 1'b0;
    else if (wr_accept)
      r_par[wr_addr] <= ^wr_data;
  end
`endif

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign w_regs_flat[g*XLEN +: XLEN] = r_regs[g];
`ifdef REGFILE_PARITY_EN
    assign w_par_flat[g] = r_par[g];
`endif
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    regfile_rdport #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .BYPASS (BYPASS),
      .AW     (AW)
    ) u_rdport (
      .i_ready     (ready),
      .i_rd_addr   (rd_addr[g*AW +: AW]),
      .i_regs      (w_regs_flat),
`ifdef REGFILE_PARITY_EN
      .i_par       (w_par_flat),
      .o_rd_perr   (rd_perr[g]),
`endif
      .i_wr_accept (wr_accept),
      .i_wr_addr   (wr_addr),
      .i_wr_data   (wr_data),
      .o_rd_data   (rd_data[g*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a 3-port bypassing instance and a 2-port
// non-bypassing instance share the write port and clock.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] rd_addr;
  logic [95:0] rd_data;
  logic [9:0]  nb_addr;
  logic [63:0] nb_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_accept, ready, busy;
  logic        nb_accept, nb_ready, nb_busy;
`ifdef REGFILE_PARITY_EN
  logic [2:0]  rd_perr;
  logic [1:0]  nb_perr;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(3), .BYPASS(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_accept (wr_accept),
    .ready     (ready),
`ifdef REGFILE_PARITY_EN
    .rd_perr   (rd_perr),
`endif
    .busy      (busy)
  );

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) dut_nb (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (nb_addr),
    .rd_data   (nb_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_accept (nb_accept),
    .ready     (nb_ready),
`ifdef REGFILE_PARITY_EN
    .rd_perr   (nb_perr),
`endif
    .busy      (nb_busy)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0, ra1, ra2;
    logic        acc;
    logic [31:0] e0, e1, e2, enb;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  k;
    bit  got;

    tbl[0] = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd7,  5'd7,  5'd0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0};
    tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  5'd7, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  5'd0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0};
    tbl[3] = '{1'b1, 5'd3,  32'h0000A5A5, 5'd3,  5'd3,  5'd3, 1'b1, 32'h0000A5A5, 32'h0000A5A5, 32'h0000A5A5, 32'h0};
    tbl[4] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  5'd3, 1'b0, 32'h0000A5A5, 32'h0000A5A5, 32'h0000A5A5, 32'h0000A5A5};
    tbl[5] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd7,  5'd3, 1'b1, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h0000A5A5, 32'h0};
    tbl[6] = '{1'b1, 5'd7,  32'h00000001, 5'd7,  5'd31, 5'd0, 1'b1, 32'h00000001, 32'hFFFFFFFF, 32'h0,        32'hDEADBEEF};
    tbl[7] = '{1'b0, 5'd7,  32'h00000099, 5'd7,  5'd0,  5'd0, 1'b0, 32'h00000001, 32'h0,        32'h0,        32'h00000001};

    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    nb_addr = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd1);
    chk("reset_nb_ready", {31'd0, nb_ready}, 32'd0);

    // First sweep, interrupted after 10 edges.
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midsweep_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd_addr[4:0] = 5'd5;
    wr_en   = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'h55;

    k = 0;
    got = 1'b0;
    while (!got && k < 64) begin
      @(posedge clk);
      k++;
      #1;
      if (ready) begin
        got = 1'b1;
        wr_en = 1'b0;
      end else begin
        chk("sweep_rd5", rd_data[31:0], 32'h0);
        chk("sweep_wr_accept", {31'd0, wr_accept}, 32'd0);
      end
    end
    wr_en = 1'b0;
    chk("ready_edges", k, 32);
    chk("post_sweep_busy", {31'd0, busy}, 32'd0);
    chk("post_sweep_nb_ready", {31'd0, nb_ready}, 32'd1);

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rd_addr[4:0] = 5'(i);
      #2;
      chk($sformatf("cleared_x%0d", i), rd_data[31:0], 32'h0);
    end

    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      wr_en   = tbl[v].we;
      wr_addr = tbl[v].wa;
      wr_data = tbl[v].wd;
      rd_addr = {tbl[v].ra2, tbl[v].ra1, tbl[v].ra0};
      nb_addr = {5'd0, tbl[v].ra0};
      #2;
      chk($sformatf("v%0d_accept", v), {31'd0, wr_accept}, {31'd0, tbl[v].acc});
      chk($sformatf("v%0d_rd0", v), rd_data[31:0], tbl[v].e0);
      chk($sformatf("v%0d_rd1", v), rd_data[63:32], tbl[v].e1);
      chk($sformatf("v%0d_rd2", v), rd_data[95:64], tbl[v].e2);
      chk($sformatf("v%0d_nb_rd0", v), nb_data[31:0], tbl[v].enb);
    end
    @(negedge clk);
    wr_en = 1'b0;

`ifdef REGFILE_PARITY_EN
    wr_en   = 1'b1;
    wr_addr = 5'd9;
    wr_data = 32'h1;
    @(negedge clk);
    wr_en   = 1'b0;
    rd_addr = {5'd0, 5'd7, 5'd9};
    #2;
    chk("par_clean", {29'd0, rd_perr}, 32'd0);
    chk("par_x9_data", rd_data[31:0], 32'h1);
    dut.r_regs[9] = dut.r_regs[9] ^ 32'h10;
    #1;
    chk("par_flip", {29'd0, rd_perr}, 32'd1);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file; successor to the single-cycle core's 2R1W register file.
- Generalises data width, register count and read-port count.
- Adds a sequential post-reset clear sweep with busy/ready status, a configurable write-to-read bypass, and a hard-wired zero register.
- Sits between decode (read addresses) and writeback (write port).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >= 2)
NRD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = reads see pre-write contents
AW, $clog2(NREGS), address width (derived; not overridden)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high reset
rd_addr  input  NRD*AW  read addresses; port i occupies bits [i*AW +: AW]
rd_data  output  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN]
wr_en  input  1  write request
wr_addr  input  AW  write address
wr_data  input  XLEN  write data
wr_accept  output  1  write committed at this edge (wr_en & ready & wr_addr != 0)
ready  output  1  clear sweep complete; file usable
busy  output  1  clear sweep in progress (equals ~ready)

Behaviour:
- Interface: clock clk; reset reset, asynchronous, active-high.
- FSM states are CLEAR and READY.
  - Reset forces CLEAR and sets sweep pointer ptr = 0.
  - ready = 0 and busy = 1 during reset.
  - Register contents are not touched asynchronously.
- CLEAR: each rising edge writes 0 to regs[ptr] and increments ptr.
  - On the edge that writes regs[NREGS-1], the FSM moves to READY. ready rises after exactly NREGS edges following reset deassertion.
  - Reset asserted mid-sweep restarts the sweep at ptr = 0.
- While in CLEAR:
  - wr_en is ignored and wr_accept = 0.
  - All rd_data read 0, regardless of address.
- READY:
  - Write occurs at the rising edge when wr_en = 1 and wr_addr != 0.
  - Writes to address 0 are dropped with wr_accept = 0.
  - The FSM stays in READY until reset.
- Reads are combinational (zero latency) and independent per port.
  - Address 0 always returns 0.
  - BYPASS = 1: if wr_accept would be 1 this cycle and rd_addr[i] == wr_addr, rd_data[i] = wr_data in the same cycle.
  - BYPASS = 0: rd_data[i] returns the stored value; the new value is visible the cycle after the write edge.
- All NRD ports may address the same register simultaneously; each receives identical data.
- No arithmetic other than the ptr increment. ptr is AW bits wide, and the terminal test is on ptr == NREGS-1 (no wrap needed).
- wr_accept is combinational.

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- When defined:
  - Each register stores an extra even-parity bit, computed from wr_data on write and set to 0 on clear.
  - Adds output rd_perr [NRD-1:0], set per port when the stored data XOR parity is odd.
  - rd_perr is forced to 0 for address 0, during CLEAR, and on bypassed reads.
- When undefined: no parity storage and no rd_perr port.

Decomposition:
- Shared package regfile_pkg holds:
  - the state enum (RF_CLEAR, RF_READY);
  - the default XLEN and NREGS constants;
  - the zero-register index constant ZERO_REG = 0.
- One natural sub-module, regfile_rdport: per-port read mux with zero-register masking, bypass compare and parity check. It is instantiated NRD times via generate.

Test Plan:
- Clear sweep:
  - Stimulus: reset pulse; NREGS = 32; read rd_addr 5 during the sweep.
  - Required: busy = 1 for exactly 32 edges, then ready = 1; rd_data = 0 throughout; all registers read 0 afterwards.
- Reset mid-sweep:
  - Stimulus: after 10 sweep edges, assert reset for 1 cycle.
  - Required: ready rises 32 edges after the second deassertion.
- Write/read, BYPASS = 1:
  - Stimulus: write x7 = 0xDEADBEEF with rd_addr0 = 7 in the same cycle.
  - Required: rd_data0 = 0xDEADBEEF combinationally; still 0xDEADBEEF next cycle.
  - With BYPASS = 0: the old value 0 is seen the same cycle, 0xDEADBEEF the next.
- Zero register:
  - Stimulus: wr_en = 1, wr_addr = 0, wr_data = 0x12345678.
  - Required: wr_accept = 0; rd_addr 0 returns 0 on all ports.
- Write during CLEAR:
  - Stimulus: wr_en = 1 to x3 = 0x55 while busy.
  - Required: wr_accept = 0; x3 reads 0 after ready.
  - With NRD = 3: all ports reading x3 after a legal write of 0xA5A5 return 0xA5A5.
- Parity (REGFILE_PARITY_EN):
  - Stimulus: write x9 = 0x1, then force a single-bit flip of stored x9.
  - Required: rd_perr = 1 on the reading port only; 0 on an unflipped register.
